// File: rtl/mod_decode_stage_if.sv
// rtl/mod_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface mod_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [6:0]      funct7_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rs1_o;
    logic [2:0]      funct3_o;
    logic [4:0]      rd_o;
    logic [6:0]      opcode_o;
    logic [XLEN-1:0] immediate_o;
    logic [2:0]      imm_type_o;
    logic            illegal_o;

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, funct7_o, rs2_o, rs1_o, funct3_o,
               rd_o, opcode_o, immediate_o, imm_type_o, illegal_o
    );

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, funct7_o, rs2_o, rs1_o, funct3_o,
               rd_o, opcode_o, immediate_o, imm_type_o, illegal_o
    );
endinterface

// File: rtl/mod_decode_stage.sv
// rtl/mod_decode_stage.sv - registered RV decode stage with optional skid entry
module mod_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mod_decode_stage_if.slave  bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic            out_valid;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      type_q;
    logic            illegal_q;

    logic            in_ready;
    logic            accept;
    logic            xfer;

    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    logic [2:0]      f3;
    logic [31:0]     imm32;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    // Ready is forced low during reset so nothing is accepted into a clearing pipe.
    assign in_ready = SKID_EN ? (!skid_valid && !rst_i)
                              : ((!out_valid || bus.out_ready_i) && !rst_i);
    assign accept   = bus.in_valid_i && in_ready;
    assign xfer     = out_valid && bus.out_ready_i;

    // A held skid entry is always older than the input, so it wins the decoder.
    assign src_instr = skid_valid ? skid_instr : bus.instr_i;
    assign src_pc    = skid_valid ? skid_pc    : bus.pc_i;
    assign f3        = src_instr[14:12];

    always_comb begin
        imm32       = 32'd0;
        dec_type    = 3'd0;
        dec_illegal = 1'b0;
        case (src_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                dec_type = 3'd4;
                imm32    = {src_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_type = 3'd5;
                imm32    = {{12{src_instr[31]}}, src_instr[19:12], src_instr[20],
                            src_instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                dec_type = 3'd1;
                imm32    = {{21{src_instr[31]}}, src_instr[30:20]};
                if (src_instr[6:0] == OP_JALR)
                    dec_illegal = (f3 != 3'b000);
                else if (src_instr[6:0] == OP_LOAD)
                    dec_illegal = (XLEN == 64) ? (f3 == 3'b111)
                                               : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OP_STORE: begin
                dec_type    = 3'd2;
                imm32       = {{21{src_instr[31]}}, src_instr[30:25], src_instr[11:7]};
                dec_illegal = (XLEN == 64) ? (f3 > 3'b011) : (f3 > 3'b010);
            end
            OP_BRANCH: begin
                dec_type    = 3'd3;
                imm32       = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25],
                               src_instr[11:8], 1'b0};
                dec_illegal = (f3 == 3'b010 || f3 == 3'b011);
            end
            OP_OP, OP_MISC, OP_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
        if (src_instr[1:0] != 2'b11)
            dec_illegal = 1'b1;
        if (dec_illegal) begin
            imm32    = 32'd0;
            dec_type = 3'd0;
        end
    end

    assign dec_imm = XLEN'($signed(imm32));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            type_q     <= '0;
            illegal_q  <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || xfer) begin
            if (skid_valid || accept) begin
                out_valid <= 1'b1;
                pc_q      <= src_pc;
                instr_q   <= src_instr;
                imm_q     <= dec_imm;
                type_q    <= dec_type;
                illegal_q <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
            skid_valid <= 1'b0;
        end else if (SKID_EN && accept) begin
            skid_valid <= 1'b1;
            skid_instr <= bus.instr_i;
            skid_pc    <= bus.pc_i;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.pc_o        = pc_q;
    assign bus.funct7_o    = instr_q[31:25];
    assign bus.rs2_o       = instr_q[24:20];
    assign bus.rs1_o       = instr_q[19:15];
    assign bus.funct3_o    = instr_q[14:12];
    assign bus.rd_o        = instr_q[11:7];
    assign bus.opcode_o    = instr_q[6:0];
    assign bus.immediate_o = imm_q;
    assign bus.imm_type_o  = type_q;
    assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_mod_decode_stage.sv
// tb/tb_mod_decode_stage.sv - directed bench for the decode stage (RV32 with skid, RV64 without)
module tb_mod_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mod_decode_stage_if #(.XLEN(32)) bus_a ();
    mod_decode_stage_if #(.XLEN(64)) bus_b ();

    mod_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    mod_decode_stage #(.XLEN(64), .SKID_EN(1'b0)) u_dut64 (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one instruction to both stages for one edge; results are visible on return.
    task automatic dec_both(input logic [31:0] instr, input logic [31:0] pc);
        bus_a.in_valid_i = 1'b1;
        bus_a.instr_i    = instr;
        bus_a.pc_i       = pc;
        bus_b.in_valid_i = 1'b1;
        bus_b.instr_i    = instr;
        bus_b.pc_i       = {32'd0, pc};
        @(posedge clk);
        @(negedge clk);
        bus_a.in_valid_i = 1'b0;
        bus_b.in_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] addi_x1(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s_instr [4];
        int sent;
        int got;

        bus_a.flush_i = 0; bus_a.in_valid_i = 0; bus_a.instr_i = 0; bus_a.pc_i = 0; bus_a.out_ready_i = 0;
        bus_b.flush_i = 0; bus_b.in_valid_i = 0; bus_b.instr_i = 0; bus_b.pc_i = 0; bus_b.out_ready_i = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus_a.in_ready_o, 0);
        check("rst_out_valid", bus_a.out_valid_o, 0);
        check("rst_imm", bus_a.immediate_o, 0);
        check("rst_in_ready64", bus_b.in_ready_o, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus_a.in_ready_o, 1);
        bus_a.out_ready_i = 1'b1;
        bus_b.out_ready_i = 1'b1;

        dec_both(32'hFFF00093, 32'h100);
        check("addi_valid", bus_a.out_valid_o, 1);
        check("addi_rd", bus_a.rd_o, 1);
        check("addi_rs1", bus_a.rs1_o, 0);
        check("addi_imm", bus_a.immediate_o, 64'hFFFF_FFFF);
        check("addi_type", bus_a.imm_type_o, 1);
        check("addi_ill", bus_a.illegal_o, 0);
        check("addi_pc", bus_a.pc_o, 32'h100);
        check("addi_imm64", bus_b.immediate_o, 64'hFFFF_FFFF_FFFF_FFFF);

        dec_both(32'hFE000E63, 32'h104);
        check("beq_e63_imm", bus_a.immediate_o, 64'hFFFF_F7FC);
        check("beq_e63_type", bus_a.imm_type_o, 3);
        dec_both(32'hFE000EE3, 32'h108);
        check("beq_m4_imm", bus_a.immediate_o, 64'hFFFF_FFFC);
        check("beq_m4_type", bus_a.imm_type_o, 3);

        dec_both(32'h0040006F, 32'h10C);
        check("jal_imm", bus_a.immediate_o, 4);
        check("jal_type", bus_a.imm_type_o, 5);

        dec_both(32'h800000B7, 32'h110);
        check("lui_imm32", bus_a.immediate_o, 64'h8000_0000);
        check("lui_imm64", bus_b.immediate_o, 64'hFFFF_FFFF_8000_0000);
        check("lui_type64", bus_b.imm_type_o, 4);
        check("lui_rd64", bus_b.rd_o, 1);

        dec_both(32'hFFFFF117, 32'h114);
        check("auipc_imm64", bus_b.immediate_o, 64'hFFFF_FFFF_FFFF_F000);
        check("auipc_rd", bus_a.rd_o, 2);

        dec_both(32'h00112623, 32'h118);
        check("sw_imm", bus_a.immediate_o, 12);
        check("sw_type", bus_a.imm_type_o, 2);
        check("sw_rs1", bus_a.rs1_o, 2);
        check("sw_rs2", bus_a.rs2_o, 1);
        check("sw_f3", bus_a.funct3_o, 2);

        dec_both(32'h00113623, 32'h11C);
        check("sd_ill32", bus_a.illegal_o, 1);
        check("sd_imm32", bus_a.immediate_o, 0);
        check("sd_ill64", bus_b.illegal_o, 0);
        check("sd_imm64", bus_b.immediate_o, 12);

        dec_both(32'h00006083, 32'h120);
        check("lwu_ill32", bus_a.illegal_o, 1);
        check("lwu_ill64", bus_b.illegal_o, 0);
        check("lwu_type64", bus_b.imm_type_o, 1);

        dec_both(32'h00000000, 32'h124);
        check("zero_valid", bus_a.out_valid_o, 1);
        check("zero_ill", bus_a.illegal_o, 1);
        check("zero_type", bus_a.imm_type_o, 0);

        dec_both(32'h000010E7, 32'h128);
        check("jalr_f3_ill", bus_a.illegal_o, 1);
        check("jalr_f3_imm", bus_a.immediate_o, 0);
        check("jalr_f3_rd", bus_a.rd_o, 1);
        check("jalr_f3_op", bus_a.opcode_o, 7'h67);

        dec_both(32'h00002063, 32'h12C);
        check("blt_f3_010_ill", bus_a.illegal_o, 1);

        dec_both(32'h402081B3, 32'h130);
        check("sub_ill", bus_a.illegal_o, 0);
        check("sub_type", bus_a.imm_type_o, 0);
        check("sub_f7", bus_a.funct7_o, 7'h20);
        check("sub_rd", bus_a.rd_o, 3);
        @(posedge clk);
        @(negedge clk);
        check("drain_valid", bus_a.out_valid_o, 0);

        // Back-to-back stream into a stalled consumer
        for (int k = 0; k < 4; k++) s_instr[k] = addi_x1(k + 1);
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            bus_a.in_valid_i  = (sent < 4);
            if (sent < 4) begin
                bus_a.instr_i = s_instr[sent];
                bus_a.pc_i    = 32'h200 + 32'(sent) * 4;
            end
            bus_a.out_ready_i = (c >= 3);
            #1;
            if (c == 2) check("skid_in_ready", bus_a.in_ready_o, 0);
            if (bus_a.out_valid_o && bus_a.out_ready_i) begin
                check("stream_imm", bus_a.immediate_o, 64'(got + 1));
                check("stream_pc", bus_a.pc_o, 64'(32'h200 + got * 4));
                got++;
            end
            if (bus_a.in_valid_i && bus_a.in_ready_o) sent++;
            @(negedge clk);
        end
        bus_a.in_valid_i = 1'b0;
        check("stream_count", 64'(got), 4);
        @(posedge clk);
        @(negedge clk);
        check("stream_no_dup", bus_a.out_valid_o, 0);

        // Flush with both output and skid occupied
        bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i  = 1'b1;
        bus_a.instr_i = addi_x1(17); bus_a.pc_i = 32'h300;
        @(posedge clk); @(negedge clk);
        bus_a.instr_i = addi_x1(18); bus_a.pc_i = 32'h304;
        @(posedge clk); @(negedge clk);
        check("flush_pre_ready", bus_a.in_ready_o, 0);
        bus_a.flush_i = 1'b1;
        bus_a.instr_i = addi_x1(19); bus_a.pc_i = 32'h308;
        @(posedge clk); @(negedge clk);
        check("flush_valid", bus_a.out_valid_o, 0);
        check("flush_ready", bus_a.in_ready_o, 1);
        bus_a.flush_i = 1'b0;
        bus_a.instr_i = addi_x1(20); bus_a.pc_i = 32'h310;
        bus_a.out_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_a.in_valid_i = 1'b0;
        check("post_flush_valid", bus_a.out_valid_o, 1);
        check("post_flush_imm", bus_a.immediate_o, 20);
        check("post_flush_pc", bus_a.pc_o, 32'h310);
        @(posedge clk); @(negedge clk);
        check("post_flush_drain", bus_a.out_valid_o, 0);

        // Asynchronous reset while stalled
        bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i  = 1'b1;
        bus_a.instr_i = addi_x1(33); bus_a.pc_i = 32'h400;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        bus_a.in_valid_i = 1'b0;
        check("stall_valid", bus_a.out_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus_a.out_valid_o, 0);
        check("async_rst_imm", bus_a.immediate_o, 0);
        check("async_rst_ready", bus_a.in_ready_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_a.out_ready_i = 1'b1;
        #1;
        check("rst_release_ready", bus_a.in_ready_o, 1);
        @(posedge clk); @(negedge clk);
        check("no_replay", bus_a.out_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
